// File: rtl/seq_shifter_if.sv
// Request/result bundle for the sequential shifter.
// The master drives the operation fields and start; the slave returns status and the result.
interface seq_shifter_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [AMT_W-1:0] amt;
  logic             lr;
  logic             la;
  logic             rot;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             c;

  modport master (
    output start, a, amt, lr, la, rot,
    input  busy, done, y, c
  );

  modport slave (
    input  start, a, amt, lr, la, rot,
    output busy, done, y, c
  );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one 1-bit shift/rotate per clock, amt iterations,
// with a single-cycle done pulse at the end.
module seq_shifter #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_shifter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] y_reg;
  logic             c_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [AMT_W-1:0] count_reg;
  logic             lr_reg;
  logic             la_reg;
  logic             rot_reg;

  logic [WIDTH-1:0] y_next;
  logic             c_next;
  logic             fill_bit;

  // Bit entering the vacated end: rotate wins over arithmetic fill.
  always_comb begin
    fill_bit = 1'b0;
    y_next   = y_reg;
    c_next   = c_reg;
    if (!lr_reg) begin
      fill_bit = rot_reg ? y_reg[WIDTH-1] : 1'b0;
      y_next   = {y_reg[WIDTH-2:0], fill_bit};
      c_next   = y_reg[WIDTH-1];
    end else begin
      if (rot_reg) begin
        fill_bit = y_reg[0];
      end else if (la_reg) begin
        fill_bit = y_reg[WIDTH-1];
      end else begin
        fill_bit = 1'b0;
      end
      y_next = {fill_bit, y_reg[WIDTH-1:1]};
      c_next = y_reg[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      y_reg     <= '0;
      c_reg     <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      count_reg <= '0;
      lr_reg    <= 1'b0;
      la_reg    <= 1'b0;
      rot_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            y_reg     <= bus.a;
            c_reg     <= 1'b0;
            count_reg <= bus.amt;
            lr_reg    <= bus.lr;
            la_reg    <= bus.la;
            rot_reg   <= bus.rot;
            if (bus.amt != '0) begin
              state_reg <= SHIFT;
              busy_reg  <= 1'b1;
            end else begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          y_reg     <= y_next;
          c_reg     <= c_next;
          count_reg <= count_reg - AMT_W'(1);
          if (count_reg == AMT_W'(1)) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.y    = y_reg;
  assign bus.c    = c_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter (WIDTH=8, AMT_W=3): expected {c,y} pushed at
// start, popped and compared when done is observed.
module tb_seq_shifter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [8:0] sb[$];

  seq_shifter_if #(.WIDTH(8), .AMT_W(3)) bus ();

  seq_shifter #(.WIDTH(8), .AMT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: iterate the single-bit operations on an integer copy.
  function automatic logic [8:0] model(input logic [7:0] a, input int amt,
                                       input bit lr, input bit la, input bit rot);
    int v;
    int cc;
    int msb;
    v  = int'(a);
    cc = 0;
    for (int i = 0; i < amt; i++) begin
      if (!lr) begin
        cc = (v >> 7) & 1;
        v  = ((v << 1) | (rot ? cc : 0)) & 255;
      end else begin
        cc  = v & 1;
        msb = rot ? cc : (la ? ((v >> 7) & 1) : 0);
        v   = (v >> 1) | (msb << 7);
      end
    end
    return {cc[0], v[7:0]};
  endfunction

  task automatic issue(input logic [7:0] a, input logic [2:0] amt,
                       input bit lr, input bit la, input bit rot);
    @(negedge clk);
    bus.a     = a;
    bus.amt   = amt;
    bus.lr    = lr;
    bus.la    = la;
    bus.rot   = rot;
    bus.start = 1'b1;
    sb.push_back(model(a, int'(amt), lr, la, rot));
    $display("op a=%h amt=%0d lr=%0d la=%0d rot=%0d expect y=%h c=%0d",
             a, amt, lr, la, rot, sb[$][7:0], sb[$][8]);
  endtask

  // Advances until done is seen (bounded); optional junk start while busy.
  task automatic wait_done(input bit inject, output int cycles, output int busy_cycles,
                           output bit overlap, output bit timeout);
    cycles = 0; busy_cycles = 0; overlap = 1'b0; timeout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cycles++;
      bus.start = 1'b0;
      if (inject && (cycles == 1 || cycles == 2)) begin
        bus.start = 1'b1;
        bus.a = 8'hFF; bus.amt = 3'd7; bus.lr = 1'b1; bus.la = 1'b1; bus.rot = 1'b0;
      end
      if (bus.busy) busy_cycles++;
      if (bus.busy && bus.done) overlap = 1'b1;
      if (bus.done) begin
        timeout = 1'b0;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b1; bus.a = 8'hAA; bus.amt = 3'd0;
    bus.lr = 1'b0; bus.la = 1'b0; bus.rot = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.y, bus.c, bus.busy, bus.done} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state got y=%h c=%b busy=%b done=%b want all 0",
               bus.y, bus.c, bus.busy, bus.done);
    end
    rst_n = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    $display("reset done");
  endtask

  task automatic test_lsl();
    int cyc, bcyc; bit ov, to; logic [8:0] exp;
    issue(8'h96, 3'd3, 1'b0, 1'b0, 1'b0);
    wait_done(1'b0, cyc, bcyc, ov, to);
    exp = sb.pop_front();
    checks++;
    if (to || cyc != 4 || bcyc != 3 || ov) begin
      errors++;
      $display("FAIL lsl_timing got done_cycle=%0d busy_cycles=%0d overlap=%b timeout=%b want 4 3 0 0",
               cyc, bcyc, ov, to);
    end
    checks++;
    if ({bus.c, bus.y} !== exp || exp !== 9'h0B0) begin
      errors++;
      $display("FAIL lsl_result got c=%b y=%h want c=0 y=b0", bus.c, bus.y);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.y !== 8'hB0 || bus.c !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_hold got done=%b y=%h c=%b want 0 b0 0", bus.done, bus.y, bus.c);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.y !== 8'hB0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold got y=%h busy=%b want b0 0", bus.y, bus.busy);
    end
  endtask

  task automatic test_shift_right_rotate();
    int cyc, bcyc; bit ov, to; logic [8:0] exp;
    logic [8:0] want [4] = '{9'h125, 9'h1E5, 9'h069, 9'h103};
    logic [7:0] av   [4] = '{8'h96, 8'h96, 8'h96, 8'h81};
    logic [2:0] amv  [4] = '{3'd2, 3'd2, 3'd4, 3'd1};
    bit lrv [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    bit lav [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    bit rtv [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      issue(av[k], amv[k], lrv[k], lav[k], rtv[k]);
      wait_done(1'b0, cyc, bcyc, ov, to);
      exp = sb.pop_front();
      checks++;
      if (to || {bus.c, bus.y} !== exp || exp !== want[k] || cyc != int'(amv[k]) + 1) begin
        errors++;
        $display("FAIL dir_op%0d got c=%b y=%h cycles=%0d want c=%b y=%h cycles=%0d",
                 k, bus.c, bus.y, cyc, want[k][8], want[k][7:0], int'(amv[k]) + 1);
      end
    end
  endtask

  task automatic test_zero_amt();
    int cyc, bcyc; bit ov, to; logic [8:0] exp;
    issue(8'h5A, 3'd0, 1'b1, 1'b1, 1'b0);
    wait_done(1'b0, cyc, bcyc, ov, to);
    exp = sb.pop_front();
    checks++;
    if (to || cyc != 1 || bcyc != 0 || {bus.c, bus.y} !== exp || exp !== 9'h05A) begin
      errors++;
      $display("FAIL zero_amt got cycles=%0d busy=%0d c=%b y=%h want 1 0 0 5a",
               cyc, bcyc, bus.c, bus.y);
    end
  endtask

  task automatic test_ignore_start();
    int cyc, bcyc; bit ov, to; logic [8:0] exp;
    issue(8'h3C, 3'd4, 1'b0, 1'b0, 1'b1);
    wait_done(1'b1, cyc, bcyc, ov, to);
    exp = sb.pop_front();
    checks++;
    if (to || cyc != 5 || {bus.c, bus.y} !== exp) begin
      errors++;
      $display("FAIL ignore_start got cycles=%0d c=%b y=%h want 5 c=%b y=%h",
               cyc, bus.c, bus.y, exp[8], exp[7:0]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL no_queue got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_mid_reset();
    int cyc, bcyc; bit ov, to; bit saw_done; logic [8:0] exp;
    issue(8'hC3, 3'd5, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    void'(sb.pop_front());
    checks++;
    if ({bus.y, bus.c, bus.busy, bus.done} !== 11'd0) begin
      errors++;
      $display("FAIL mid_reset got y=%h c=%b busy=%b done=%b want all 0",
               bus.y, bus.c, bus.busy, bus.done);
    end
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort_no_done got done pulse=1 want 0");
    end
    issue(8'hC3, 3'd5, 1'b1, 1'b1, 1'b0);
    wait_done(1'b0, cyc, bcyc, ov, to);
    exp = sb.pop_front();
    checks++;
    if (to || cyc != 6 || {bus.c, bus.y} !== exp) begin
      errors++;
      $display("FAIL after_reset got cycles=%0d c=%b y=%h want 6 c=%b y=%h",
               cyc, bus.c, bus.y, exp[8], exp[7:0]);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bcyc; bit ov, to; logic [8:0] exp;
    for (int k = 0; k < 12; k++) begin
      issue(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom));
      wait_done(1'b0, cyc, bcyc, ov, to);
      exp = sb.pop_front();
      checks++;
      if (to || ov || {bus.c, bus.y} !== exp || bcyc != cyc - 1) begin
        errors++;
        $display("FAIL b2b_%0d got c=%b y=%h busy=%0d cycles=%0d overlap=%b want c=%b y=%h",
                 k, bus.c, bus.y, bcyc, cyc, ov, exp[8], exp[7:0]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.amt = '0;
    bus.lr = 1'b0; bus.la = 1'b0; bus.rot = 1'b0;
    test_reset();
    test_lsl();
    test_shift_right_rotate();
    test_zero_amt();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 Parameter WIDTH, default 8; data width in bits, minimum 2.
REQ-002 Parameter AMT_W, default 3; shift-amount width in bits, minimum 1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request; SHALL be sampled only in IDLE.
REQ-006 a  input  WIDTH  operand.
REQ-007 amt  input  AMT_W  shift count, unsigned.
REQ-008 lr  input  1  direction: 0 = left, 1 = right.
REQ-009 la  input  1  right-shift type: 0 = logical, 1 = arithmetic; ignored when lr=0 or rot=1.
REQ-010 rot  input  1  1 = rotate (ROL/ROR per lr); overrides la.
REQ-011 busy  output  1  high while in SHIFT.
REQ-012 done  output  1  one-cycle pulse; result valid.
REQ-013 y  output  WIDTH  result register.
REQ-014 c  output  1  last bit shifted or rotated out.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-016 IDLE with start=1 SHALL capture a into y, capture amt, lr, la and rot, and clear c; next state SHALL be SHIFT if amt!=0, else DONE.
REQ-017 Each SHIFT cycle SHALL perform exactly one 1-bit operation on y and decrement the remaining count; after the operation with count==1, next state SHALL be DONE.
REQ-018 LSL: y <= {y[WIDTH-2:0],0}; c <= y[WIDTH-1].
REQ-019 LSR: y <= {0,y[WIDTH-1:1]}; c <= y[0].
REQ-020 ASR: y <= {y[WIDTH-1],y[WIDTH-1:1]}; c <= y[0].
REQ-021 ROL: y <= {y[WIDTH-2:0],y[WIDTH-1]}; c <= y[WIDTH-1].
REQ-022 ROR: y <= {y[0],y[WIDTH-1:1]}; c <= y[0].
REQ-023 amt >= WIDTH SHALL be legal; the operation SHALL iterate the full amt cycles (e.g. LSL yields 0, ASR yields sign fill).
REQ-024 DONE SHALL assert done for exactly one cycle and return to IDLE unconditionally.
REQ-025 Latency: done SHALL be high amt+1 cycles after the start edge (amt=0 -> 1 cycle).
REQ-026 start during SHIFT or DONE SHALL be ignored; no queuing; inputs a/amt/lr/la/rot SHALL be don't-care outside the capture cycle.
REQ-027 busy SHALL be 1 exactly in SHIFT; busy and done SHALL never be high together.
REQ-028 y and c SHALL hold their values in IDLE until the next accepted start.
REQ-029 Back-to-back: start SHALL be accepted in the IDLE cycle immediately following DONE.

Reset
REQ-030 rst_n=0 at a clock edge SHALL force IDLE, y=0, c=0, busy=0, done=0, count=0, regardless of state.
REQ-031 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse.
REQ-032 rst_n SHALL take priority over start on the same edge.

Verification (WIDTH=8, AMT_W=3)
REQ-033 LSL a=0x96 amt=3 -> busy 3 cycles, done at cycle 4, y=0xB0, c=0.
REQ-034 LSR a=0x96 amt=2 -> y=0x25, c=1; ASR same operands -> y=0xE5, c=1.
REQ-035 ROR a=0x96 amt=4 -> y=0x69, c=0; ROL a=0x81 amt=1 -> y=0x03, c=1.
REQ-036 amt=0, a=0x5A -> done 1 cycle after start, busy never high, y=0x5A, c=0.
REQ-037 start re-pulsed during SHIFT with different a -> ignored; result matches first operation.
REQ-038 rst_n=0 during SHIFT cycle 2 of amt=5 -> next cycle y=0, c=0, busy=0, no done; new start then completes normally.
